// File: rtl/spw_rx_pack_pkg.sv
// Shared definitions for the SpaceWire RX word packer.
// Holds the packer state encoding, SpaceWire control character codes, status word
// bit positions, the control-flag index of a 9-bit RX character and the character
// decode function.
package spw_rx_pack_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StWait,
    StCapture,
    StEmitData,
    StEmitStatus
  } rx_state_e;

  localparam logic [7:0] SPW_EOP = 8'h00;
  localparam logic [7:0] SPW_EEP = 8'h01;

  localparam int unsigned StatEepBit = 31;
  localparam int unsigned StatSatBit = 30;
  localparam int unsigned StatBadBit = 29;

  localparam int unsigned FlagIdx = 8;

  typedef struct packed {
    logic is_data;
    logic is_eep;  // EEP, including any unknown control code
    logic is_bad;  // control code that is neither EOP nor EEP
  } char_dec_t;

  function automatic char_dec_t decode_char(input logic [8:0] ch);
    char_dec_t d;
    d.is_data = ~ch[FlagIdx];
    d.is_eep  = ch[FlagIdx] && (ch[7:0] != SPW_EOP);
    d.is_bad  = ch[FlagIdx] && (ch[7:0] != SPW_EOP) && (ch[7:0] != SPW_EEP);
    return d;
  endfunction

endpackage

// File: rtl/spw_rx_word_packer.sv
// Pops 9-bit characters from the SpaceWire RX FIFO, packs data bytes little-endian
// into 32-bit words and closes each packet with a status word
// {EEP, saturated, bad control, zeros, byte count}.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   fifo_empty_rx, fifo_rd_en  RX FIFO empty flag and single-cycle pop request
//   fifo_data                  popped character, valid the cycle after fifo_rd_en
//   out_valid, out_ready       output stream handshake
//   out_data, out_bytes        word and its valid byte count (0 on a status word)
//   out_status, out_last       word is the packet status word
module spw_rx_word_packer
  import spw_rx_pack_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty_rx,
  output logic        fifo_rd_en,
  input  logic [8:0]  fifo_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        out_status,
  output logic        out_last
);

  localparam logic [LEN_W-1:0] CountMax     = '1;
  localparam logic [LEN_W-1:0] CountNearMax = CountMax - LEN_W'(1);

  rx_state_e        state_q, state_d;
  logic [31:0]      lanes_q, lanes_d;
  logic [2:0]       lane_idx_q, lane_idx_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             eep_q, eep_d;
  logic             bad_q, bad_d;
  logic             pend_q, pend_d;
  logic             rd_en_q, rd_en_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q, data_d;
  logic [2:0]       bytes_q, bytes_d;
  logic             status_q, status_d;
  char_dec_t        dec;

  function automatic logic [31:0] status_word(input logic eep, input logic sat,
                                              input logic bad, input logic [LEN_W-1:0] cnt);
    logic [31:0] w;
    w              = '0;
    w[LEN_W-1:0]   = cnt;
    w[StatEepBit]  = eep;
    w[StatSatBit]  = sat;
    w[StatBadBit]  = bad;
    return w;
  endfunction

  always_comb begin
    dec        = decode_char(fifo_data);
    state_d    = state_q;
    lanes_d    = lanes_q;
    lane_idx_d = lane_idx_q;
    count_d    = count_q;
    sat_d      = sat_q;
    eep_d      = eep_q;
    bad_d      = bad_q;
    pend_d     = pend_q;
    rd_en_d    = 1'b0;
    valid_d    = valid_q;
    data_d     = data_q;
    bytes_d    = bytes_q;
    status_d   = status_q;

    case (state_q)
      StFetch: begin
        if (!fifo_empty_rx) begin
          rd_en_d = 1'b1;
          state_d = StWait;
        end
      end
      StWait: state_d = StCapture;
      StCapture: begin
        if (dec.is_data) begin
          lanes_d[{lane_idx_q[1:0], 3'b000} +: 8] = fifo_data[7:0];
          lane_idx_d = lane_idx_q + 3'd1;
          // Count holds at all-ones; reaching it flags the length as untrustworthy.
          if (count_q >= CountNearMax) begin
            count_d = CountMax;
            sat_d   = 1'b1;
          end else begin
            count_d = count_q + LEN_W'(1);
          end
          if (lane_idx_q == 3'd3) begin
            state_d  = StEmitData;
            valid_d  = 1'b1;
            data_d   = lanes_d;
            bytes_d  = 3'd4;
            status_d = 1'b0;
          end else begin
            state_d = StFetch;
          end
        end else begin
          eep_d = dec.is_eep;
          bad_d = dec.is_bad;
          valid_d = 1'b1;
          if (lane_idx_q != 3'd0) begin
            // Flush the partial word first; status follows.
            pend_d   = 1'b1;
            state_d  = StEmitData;
            data_d   = lanes_q;
            bytes_d  = lane_idx_q;
            status_d = 1'b0;
          end else begin
            state_d  = StEmitStatus;
            data_d   = status_word(dec.is_eep, sat_q, dec.is_bad, count_q);
            bytes_d  = 3'd0;
            status_d = 1'b1;
          end
        end
      end
      StEmitData: begin
        if (out_ready) begin
          lanes_d    = '0;
          lane_idx_d = '0;
          if (pend_q) begin
            state_d  = StEmitStatus;
            valid_d  = 1'b1;
            data_d   = status_word(eep_q, sat_q, bad_q, count_q);
            bytes_d  = 3'd0;
            status_d = 1'b1;
          end else begin
            state_d  = StFetch;
            valid_d  = 1'b0;
            data_d   = '0;
            bytes_d  = 3'd0;
            status_d = 1'b0;
          end
        end
      end
      StEmitStatus: begin
        if (out_ready) begin
          count_d  = '0;
          sat_d    = 1'b0;
          eep_d    = 1'b0;
          bad_d    = 1'b0;
          pend_d   = 1'b0;
          state_d  = StFetch;
          valid_d  = 1'b0;
          data_d   = '0;
          bytes_d  = 3'd0;
          status_d = 1'b0;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      lanes_q    <= '0;
      lane_idx_q <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      eep_q      <= 1'b0;
      bad_q      <= 1'b0;
      pend_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      bytes_q    <= '0;
      status_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lanes_q    <= lanes_d;
      lane_idx_q <= lane_idx_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      eep_q      <= eep_d;
      bad_q      <= bad_d;
      pend_q     <= pend_d;
      rd_en_q    <= rd_en_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      bytes_q    <= bytes_d;
      status_q   <= status_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_bytes  = bytes_q;
  assign out_status = status_q;
  assign out_last   = status_q;

endmodule

// File: tb/tb_spw_rx_word_packer.sv
// Self-checking bench for spw_rx_word_packer: a queue-based RX FIFO, a packet-level
// reference model producing the expected word stream, and directed plus random packets.
module tb_spw_rx_word_packer;

  localparam int unsigned LenW   = 4;
  localparam int          LenMax = (1 << LenW) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty_rx = 1'b1;
  logic        fifo_rd_en;
  logic [8:0]  fifo_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_status;
  logic        out_last;

  spw_rx_word_packer #(.LEN_W(LenW)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty_rx(fifo_empty_rx),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data    (fifo_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_bytes    (out_bytes),
    .out_status   (out_status),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        status;
  } word_t;

  word_t      exp_q[$];
  logic [8:0] src_q[$];
  logic [8:0] fifo_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  int feed_pct = 100;

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_rd = 1'b0;
  logic        prev_status = 1'b0;
  logic [31:0] prev_data = '0;
  logic [2:0]  prev_bytes = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] data, input logic [2:0] bytes,
                             input logic status);
    word_t w;
    w.data = data;
    w.bytes = bytes;
    w.status = status;
    exp_q.push_back(w);
  endtask

  // Packet-level reference: chunk into little-endian words, then one status word.
  task automatic model_packet(input logic [7:0] pkt[$], input logic [8:0] term);
    int n;
    int cnt;
    logic [31:0] st;
    logic [31:0] d;
    n = pkt.size();
    for (int i = 0; i < n; i += 4) begin
      d = '0;
      for (int k = 0; k < 4 && i + k < n; k++) d |= 32'(pkt[i+k]) << (8 * k);
      expect_word(d, 3'((n - i) < 4 ? (n - i) : 4), 1'b0);
    end
    cnt = (n >= LenMax) ? LenMax : n;
    st = 32'(cnt);
    if (term[7:0] != 8'h00) st |= 32'h8000_0000;
    if (n >= LenMax)        st |= 32'h4000_0000;
    if (term[7:0] > 8'h01)  st |= 32'h2000_0000;
    expect_word(st, 3'd0, 1'b1);
  endtask

  task automatic send_chars(input logic [7:0] pkt[$], input logic [8:0] term);
    for (int i = 0; i < pkt.size(); i++) src_q.push_back({1'b0, pkt[i]});
    src_q.push_back(term);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0 || fifo_q.size() != 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (10) @(posedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // FIFO model, stream source/sink and the single compare point.
  always @(negedge clk) begin
    word_t e;
    if (!reset) begin
      if (fifo_rd_en) begin
        check("rd_en while fifo empty", 32'(fifo_empty_rx), 32'd0);
        check("rd_en while word pending", 32'(out_valid), 32'd0);
        check("second outstanding read", 32'(prev_rd), 32'd0);
        if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
      end
      if (prev_valid && !prev_ready) begin
        check("valid held under backpressure", 32'(out_valid), 32'd1);
        check("out_data stable", out_data, prev_data);
        check("out_bytes stable", 32'(out_bytes), 32'(prev_bytes));
        check("out_status stable", 32'(out_status), 32'(prev_status));
      end
    end
    if (src_q.size() != 0 && $urandom_range(0, 99) < feed_pct) fifo_q.push_back(src_q.pop_front());
    fifo_empty_rx = (fifo_q.size() == 0);
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 99) < 65);
      default: out_ready = 1'b0;
    endcase
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected word: got data 0x%08h bytes %0d status %0b, expected none",
                 out_data, out_bytes, out_status);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_bytes", 32'(out_bytes), 32'(e.bytes));
        check("out_status", 32'(out_status), 32'(e.status));
        check("out_last", 32'(out_last), 32'(e.status));
      end
    end
    prev_valid  = !reset && out_valid;
    prev_ready  = out_ready;
    prev_rd     = !reset && fifo_rd_en;
    prev_data   = out_data;
    prev_bytes  = out_bytes;
    prev_status = out_status;
  end

  initial begin
    logic [7:0] pkt[$];
    logic [8:0] term;
    int guard;
    int kind;
    int len;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_bytes", 32'(out_bytes), 32'd0);
    check("reset out_status", 32'(out_status), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    reset = 1'b0;

    // Five bytes + EOP.
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    expect_word(32'h4433_2211, 3'd4, 1'b0);
    expect_word(32'h0000_0055, 3'd1, 1'b0);
    expect_word(32'h0000_0005, 3'd0, 1'b1);
    send_chars(pkt, 9'h100);
    wait_drain("drain five-byte packet", 500);

    // Empty packet closed by EEP.
    pkt.delete();
    expect_word(32'h8000_0000, 3'd0, 1'b1);
    send_chars(pkt, 9'h101);
    wait_drain("drain empty EEP packet", 500);

    // Four bytes + unknown control code.
    pkt = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
    expect_word(32'hAAAA_AAAA, 3'd4, 1'b0);
    expect_word(32'hA000_0004, 3'd0, 1'b1);
    send_chars(pkt, 9'h107);
    wait_drain("drain bad-control packet", 500);

    // Backpressure for 20 cycles on the first data word.
    ready_mode = 2;
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    expect_word(32'h0403_0201, 3'd4, 1'b0);
    expect_word(32'h0000_0605, 3'd2, 1'b0);
    expect_word(32'h0000_0006, 3'd0, 1'b1);
    send_chars(pkt, 9'h100);
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("stalled word presented", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("rd_en low while stalled", 32'(fifo_rd_en), 32'd0);
    end
    check("characters held during stall", 32'(fifo_q.size() + src_q.size()), 32'd3);
    ready_mode = 0;
    wait_drain("drain after stall", 500);

    // 20 bytes with a 4-bit counter saturates at 15.
    pkt.delete();
    for (int i = 1; i <= 20; i++) pkt.push_back(8'(i));
    expect_word(32'h0403_0201, 3'd4, 1'b0);
    expect_word(32'h0807_0605, 3'd4, 1'b0);
    expect_word(32'h0C0B_0A09, 3'd4, 1'b0);
    expect_word(32'h100F_0E0D, 3'd4, 1'b0);
    expect_word(32'h1413_1211, 3'd4, 1'b0);
    expect_word(32'h4000_000F, 3'd0, 1'b1);
    send_chars(pkt, 9'h100);
    wait_drain("drain saturating packet", 1000);

    // Reset after two bytes, then a fresh one-byte packet.
    src_q.push_back(9'h0AA);
    src_q.push_back(9'h0BB);
    guard = 0;
    while ((src_q.size() != 0 || fifo_q.size() != 0) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("mid-packet reset out_valid", 32'(out_valid), 32'd0);
    check("mid-packet reset out_data", out_data, 32'd0);
    reset = 1'b0;
    pkt = '{8'h01};
    expect_word(32'h0000_0001, 3'd1, 1'b0);
    expect_word(32'h0000_0001, 3'd0, 1'b1);
    send_chars(pkt, 9'h100);
    wait_drain("drain after mid-packet reset", 500);

    // Random packets, random feed rate and backpressure.
    ready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      pkt.delete();
      len = $urandom_range(0, 20);
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
      kind = $urandom_range(0, 2);
      if (kind == 0)      term = 9'h100;
      else if (kind == 1) term = 9'h101;
      else                term = {1'b1, 8'($urandom_range(2, 255))};
      feed_pct = $urandom_range(20, 100);
      model_packet(pkt, term);
      send_chars(pkt, term);
      guard = 0;
      while (src_q.size() != 0 && guard < 2000) begin
        @(posedge clk);
        guard++;
      end
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    wait_drain("drain random packets", 20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spw_rx_word_packer.md
# spw_rx_word_packer

Receive-side stage directly downstream of the SpaceWire core's RX FIFO. Pops 9-bit characters (flag + byte), packs data bytes little-endian into 32-bit words and closes each packet with a status word holding byte count and end type. The output is a valid/ready stream toward the HPS-facing bridge, replacing per-character PIO polling of the RX FIFO.

## Interface
- `LEN_W`, default 16: packet byte counter width; saturates, never wraps.
- `clk`  in  1  system clock (single clock domain).
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty_rx`  in  1  RX FIFO empty flag.
- `fifo_rd_en`  out  1  single-cycle pop request to the RX FIFO.
- `fifo_data`  in  9  popped character, valid the cycle after `fifo_rd_en`; bit 8 = control flag, bits 7:0 = data.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `out_data`  out  32  data word or status word.
- `out_bytes`  out  3  valid bytes in a data word (1..4), 0 on a status word.
- `out_status`  out  1  word is the packet status word.
- `out_last`  out  1  equals `out_status`; marks end of packet.

## Operation
- Character decode: flag=0 is a data byte. Flag=1 with byte 0x00 is EOP, 0x01 is EEP; any other flagged byte is EEP with the bad-control bit set.
- Byte lane: byte n of a packet goes to `out_data[8*(n%4)+7 : 8*(n%4)]`.
- Status word: bit 31 EEP, bit 30 length saturated, bit 29 bad control, bits 28:LEN_W zero, bits LEN_W-1:0 byte count, i.e. data bytes, excluding the terminator.
- State machine:
  - FETCH: if `!fifo_empty_rx` and no word pending, assert `fifo_rd_en` for 1 cycle, go to WAIT.
  - WAIT: go to CAPTURE; data is sampled at the end of CAPTURE.
  - CAPTURE:
    - Data byte: write lane, increment `lane_idx` and count. Saturate count at 2^LEN_W-1 and set the saturated bit. If 4 bytes are held go to EMIT_DATA, else FETCH.
    - EOP/EEP: latch end type. Go to EMIT_DATA with `pend_status`=1 if `lane_idx`>0, else go to EMIT_STATUS.
  - EMIT_DATA: `out_valid`=1, `out_bytes`=held byte count. On handshake clear lanes and `lane_idx`. Then go to EMIT_STATUS if `pend_status`, else FETCH.
  - EMIT_STATUS: `out_valid`=1, `out_status`=`out_last`=1. On handshake clear count, flags and `pend_status`, then go to FETCH.
- Empty packet (terminator with no data): only a status word, count 0.
- Unused lanes of a partial word output as 0x00.
- Reset values: `fifo_rd_en`, `out_valid`, `out_status`, `out_last` = 0; `out_data` = 0; `out_bytes` = 0. State = FETCH, lanes, count and flags cleared.
- Reset mid-packet discards the partial word and count. No status word is emitted for the aborted packet.

## Timing
- Throughput: at most one character per 3 cycles (FETCH, WAIT, CAPTURE), well above the SpaceWire character rate at 50 MHz.
- `fifo_rd_en` is never asserted while `fifo_empty_rx`=1 or in an EMIT state. There is never more than one outstanding read.
- Output is registered. The 4th byte arriving in CAPTURE gives `out_valid`=1 on the next cycle.
- While `out_valid && !out_ready`, `out_data`, `out_bytes`, `out_status` and `out_last` hold stable. `out_valid` never drops without a handshake, except on reset.
- Back-to-back words: after a data-word handshake the status word is valid on the very next cycle. No bubble is required, but one is allowed.
- Count saturation: on reaching 2^LEN_W-1 the count holds and the saturated bit stays set until the status word is accepted.

## Structure
- Package `spw_rx_pack_pkg` holds:
  - state enum (FETCH, WAIT, CAPTURE, EMIT_DATA, EMIT_STATUS);
  - `SPW_EOP`=8'h00 and `SPW_EEP`=8'h01;
  - status bit positions 31/30/29;
  - the 9-bit flag index 8.
- Single module; no sub-module is required. Character decode is a small combinational function kept in the package.

## Test plan
- Packet 0x11,0x22,0x33,0x44,0x55 + EOP -> data word 0x44332211 with bytes=4, then 0x00000055 with bytes=1, then status 0x00000005 with last=1.
- Immediate EEP (empty packet) -> single status word 0x80000000, bytes=0, last=1; no data word.
- 4 bytes 0xAA + flagged 0x07 -> data 0xAAAAAAAA, then status 0xA0000004 (EEP and bad-control bits set).
- `out_ready` held low 20 cycles during a data word -> outputs stable, `fifo_rd_en` stays 0, no characters lost; the sequence resumes correctly on release.
- LEN_W=4, 20 data bytes + EOP -> 5 full words, then status 0x4000000F (saturated bit set).
- Reset asserted after 2 bytes of a packet, then a new packet 0x01 + EOP -> only 0x00000001 (bytes=1) and status 0x00000001; nothing from the aborted packet.
